// File: rtl/angle_reducer.sv
`default_nettype none
// ============================================================================
// Module      : angle_reducer
// Description : Reduces an unsigned whole-degree angle modulo 360 and then
//               folds it into a quadrant (0..3) plus an offset within that
//               quadrant (0..89) for a downstream cosine/tangent LUT stage.
//               Requests use a valid/ready handshake on both sides; only one
//               request is in flight at a time.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   1           system clock, rising edge
//   reset_n     in   1           asynchronous active-low reset
//   in_valid    in   1           upstream angle request present
//   in_ready    out  1           block can accept a request (IDLE only)
//   tan_req     in   1           tangent requested, captured with the angle
//   data_in     in   DATA_WIDTH  angle in whole degrees
//   out_valid   out  1           reduced result available
//   out_ready   in   1           downstream consumes the result
//   en_tangent  out  1           registered copy of the captured tan_req
//   quadrant    out  2           quadrant of the reduced angle
//   data_out    out  DATA_WIDTH  angle folded into the quadrant, 0..89
// ============================================================================
module angle_reducer #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  tan_req,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  en_tangent,
    output logic [1:0]            quadrant,
    output logic [DATA_WIDTH-1:0] data_out
);

    // Remainder width: two guard bits over the input, and never narrower
    // than 17 bits so that the largest step (360 * 2^7 = 46080) is exact
    // even for small DATA_WIDTH values.
    localparam int RW = (DATA_WIDTH + 2 > 17) ? DATA_WIDTH + 2 : 17;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        FOLD   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                  state_q;
    logic [RW-1:0]           rem_q;
    logic [2:0]              k_q;
    logic                    tan_q;
    logic                    out_valid_q;
    logic                    en_tangent_q;
    logic [1:0]              quadrant_q;
    logic [DATA_WIDTH-1:0]   data_out_q;

    // Combinational helpers for the reduce and fold steps
    logic [RW-1:0]           step_d;
    logic [RW-1:0]           rem_red_d;
    logic [1:0]              quad_d;
    logic [RW-1:0]           base_d;
    logic [RW-1:0]           fold_d;

    // Restoring-division style reduction: try subtracting 360*2^k for
    // k = 7 down to 0. Any 16-bit angle is below 360*2^8, so eight steps
    // always leave rem in 0..359.
    always_comb begin
        step_d    = RW'(360) << k_q;
        rem_red_d = rem_q;
        if (rem_q >= step_d) begin
            rem_red_d = rem_q - step_d;
        end
    end

    // Quadrant selection and fold offset for a remainder in 0..359
    always_comb begin
        quad_d = 2'd0;
        base_d = '0;
        if (rem_q >= RW'(270)) begin
            quad_d = 2'd3;
            base_d = RW'(270);
        end else if (rem_q >= RW'(180)) begin
            quad_d = 2'd2;
            base_d = RW'(180);
        end else if (rem_q >= RW'(90)) begin
            quad_d = 2'd1;
            base_d = RW'(90);
        end
        fold_d = rem_q - base_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            rem_q        <= '0;
            k_q          <= 3'd0;
            tan_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            en_tangent_q <= 1'b0;
            quadrant_q   <= 2'd0;
            data_out_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        rem_q   <= RW'(data_in);
                        tan_q   <= tan_req;
                        k_q     <= 3'd7;
                        state_q <= REDUCE;
                    end
                end
                REDUCE: begin
                    rem_q <= rem_red_d;
                    if (k_q == 3'd0) begin
                        state_q <= FOLD;
                    end else begin
                        k_q <= k_q - 3'd1;
                    end
                end
                FOLD: begin
                    quadrant_q   <= quad_d;
                    data_out_q   <= DATA_WIDTH'(fold_d);
                    en_tangent_q <= tan_q;
                    state_q      <= DONE;
                end
                DONE: begin
                    // Result registers settle on entry to DONE; out_valid is
                    // raised one edge later so the result appears exactly ten
                    // edges after acceptance with data already stable.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Ready only in IDLE; during the DONE->IDLE edge the state is still DONE,
    // so no request can be accepted on the handoff edge.
    assign in_ready   = (state_q == IDLE);
    assign out_valid  = out_valid_q;
    assign en_tangent = en_tangent_q;
    assign quadrant   = quadrant_q;
    assign data_out   = data_out_q;

endmodule
`default_nettype wire

// File: tb/tb_angle_reducer.sv
`default_nettype none
// ============================================================================
// Module      : tb_angle_reducer
// Description : Self-checking bench for angle_reducer. Expected results are
//               pushed to a scoreboard queue when a request is accepted and
//               popped when the block raises out_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_angle_reducer;

    localparam int DATA_WIDTH = 16;

    logic                  clk;
    logic                  reset_n;
    logic                  in_valid;
    logic                  in_ready;
    logic                  tan_req;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  out_valid;
    logic                  out_ready;
    logic                  en_tangent;
    logic [1:0]            quadrant;
    logic [DATA_WIDTH-1:0] data_out;

    typedef struct {
        int quad;
        int fold;
        int tan;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    angle_reducer #(.DATA_WIDTH(DATA_WIDTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tan_req    (tan_req),
        .data_in    (data_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .en_tangent (en_tangent),
        .quadrant   (quadrant),
        .data_out   (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Issue one request, check latency and result, optionally stall the
    // consumer and optionally scramble the inputs while the block is busy.
    task automatic run_req(input int din, input bit tan, input int stall, input bit scramble);
        int   edges;
        int   r;
        exp_t e;
        exp_t got;
        @(negedge clk);
        check("in_ready_before_req", int'(in_ready), 1);
        in_valid  = 1'b1;
        data_in   = DATA_WIDTH'(din);
        tan_req   = tan;
        out_ready = (stall == 0);
        r = din % 360;
        e.quad = r / 90;
        e.fold = r % 90;
        e.tan  = int'(tan);
        @(posedge clk);
        exp_q.push_back(e);
        #1;
        in_valid = 1'b0;
        edges = 0;
        while (edges < 20) begin
            @(posedge clk);
            edges++;
            #1;
            if (scramble && edges < 8) begin
                in_valid = $urandom_range(0, 1);
                data_in  = DATA_WIDTH'($urandom);
                tan_req  = $urandom_range(0, 1);
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid) break;
        end
        check("latency_edges", edges, 10);
        if (!out_valid) begin
            check("out_valid_timeout", 0, 1);
            return;
        end
        check("scoreboard_nonempty", exp_q.size(), 1);
        if (exp_q.size() == 0) return;
        got = exp_q.pop_front();
        check($sformatf("quadrant_%0d", din), int'(quadrant), got.quad);
        check($sformatf("data_out_%0d", din), int'(data_out), got.fold);
        check($sformatf("en_tangent_%0d", din), int'(en_tangent), got.tan);
        check("in_ready_busy", int'(in_ready), 0);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check("hold_out_valid", int'(out_valid), 1);
            check("hold_quadrant", int'(quadrant), got.quad);
            check("hold_data_out", int'(data_out), got.fold);
            check("hold_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("out_valid_falls", int'(out_valid), 0);
        check("in_ready_after_handoff", int'(in_ready), 1);
        check("retain_data_out", int'(data_out), got.fold);
        check("retain_quadrant", int'(quadrant), got.quad);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        tan_req   = 1'b0;
        data_in   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_quadrant", int'(quadrant), 0);
        check("rst_data_out", int'(data_out), 0);
        check("rst_en_tangent", int'(en_tangent), 0);
        reset_n = 1'b1;

        run_req(0, 1'b0, 0, 1'b0);
        run_req(405, 1'b0, 0, 1'b0);
        run_req(720, 1'b1, 0, 1'b0);
        run_req(65535, 1'b0, 0, 1'b0);
        run_req(270, 1'b1, 5, 1'b0);
        run_req(50000, 1'b1, 0, 1'b1);
        run_req(1234, 1'b0, 2, 1'b1);

        for (int a = 0; a < 360; a++) begin
            run_req(a, 1'b1, 0, 1'b0);
        end

        // Reset during the 4th REDUCE cycle of a request for 1000 degrees
        @(negedge clk);
        in_valid  = 1'b1;
        data_in   = DATA_WIDTH'(1000);
        tan_req   = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_quadrant", int'(quadrant), 0);
        check("midrst_data_out", int'(data_out), 0);
        check("midrst_en_tangent", int'(en_tangent), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        reset_n = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 15; i++) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            check("midrst_no_out_valid", seen, 0);
        end
        run_req(100, 1'b0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run can never hang
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
